axi_burst_memory_slave: RTL and testbench

AXI_BURST_MEMORY_SLAVE -- requirements
Module: axi_burst_memory_slave

---
 rtl/axi_burst_memory_slave_if.sv | 67 ++++++
 rtl/axi_burst_memory_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_burst_memory_slave.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_memory_slave_if.sv
// AXI4 bus bundle for the burst memory slave: write address/data/response
// and read address/data channels, with master and slave views.
interface axi_burst_memory_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_burst_memory_slave.sv
// AXI4 burst memory slave with independent write/read FSMs, one burst per direction.
// Define AXI_MEM_RANGE_CHECK_EN to answer DECERR outside the mapped window instead of aliasing.
module axi_burst_memory_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_SIZE   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic                     ACLK,
  input logic                     ARESETN,
  axi_burst_memory_slave_if.slave S_AXI
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int MEM_AW     = $clog2(MEM_SIZE);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_beat;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err, w_over, w_dec;

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_next, r_next, r_beat_addr;
  logic [MEM_AW-1:0]     w_idx, r_idx;
  logic                  w_in_range, r_in_range, mem_we;
  logic [DATA_WIDTH-1:0] r_beat_data;
  logic [1:0]            r_beat_resp;

  function automatic logic burst_illegal(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len);
    return (int'(size) > ADDR_LSB) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // WRAP keeps the upper address bits of the aligned (len+1)*2^size window.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    logic [ADDR_WIDTH-1:0] incr, mask;
    incr = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b01:   return (addr & ~(incr - ADDR_WIDTH'(1))) + incr;
      2'b10:   return (addr & ~mask) | ((addr + incr) & mask);
      default: return addr;
    endcase
  endfunction

  assign w_next      = next_addr(w_addr, w_size, w_burst, w_len);
  assign r_next      = next_addr(r_addr, r_size, r_burst, r_len);
  assign r_beat_addr = (r_state == R_FETCH) ? r_addr : r_next;
  assign w_idx       = w_addr[ADDR_LSB +: MEM_AW];
  assign r_idx       = r_beat_addr[ADDR_LSB +: MEM_AW];

`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] RANGE_HI = RANGE_LO + (ADDR_WIDTH+1)'(MEM_SIZE * STRB_WIDTH);
  assign w_in_range = ({1'b0, w_addr} >= RANGE_LO) && ({1'b0, w_addr} < RANGE_HI);
  assign r_in_range = ({1'b0, r_beat_addr} >= RANGE_LO) && ({1'b0, r_beat_addr} < RANGE_HI);
`else
  assign w_in_range = 1'b1;
  assign r_in_range = 1'b1;
`endif

  assign mem_we = S_AXI.wvalid && S_AXI.wready && !w_err && w_in_range;

  always_comb begin
    r_beat_data = '0;
    r_beat_resp = RESP_OKAY;
    if (r_err)
      r_beat_resp = RESP_SLVERR;
    else if (!r_in_range)
      r_beat_resp = RESP_DECERR;
    else
      r_beat_data = mem[r_idx];
  end

  // Memory is deliberately left out of reset so contents survive an aborted burst.
  always_ff @(posedge ACLK) begin
    if (mem_we)
      for (int b = 0; b < STRB_WIDTH; b++)
        if (S_AXI.wstrb[b])
          mem[w_idx][8*b +: 8] <= S_AXI.wdata[8*b +: 8];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      w_addr        <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
      w_over        <= 1'b0;
      w_dec         <= 1'b0;
      S_AXI.awready <= 1'b0;
      S_AXI.wready  <= 1'b0;
      S_AXI.bvalid  <= 1'b0;
      S_AXI.bresp   <= RESP_OKAY;
      S_AXI.bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (S_AXI.awvalid && S_AXI.awready) begin
            S_AXI.awready <= 1'b0;
            S_AXI.wready  <= 1'b1;
            S_AXI.bid     <= S_AXI.awid;
            w_addr        <= S_AXI.awaddr;
            w_len         <= S_AXI.awlen;
            w_size        <= S_AXI.awsize;
            w_burst       <= S_AXI.awburst;
            w_err         <= burst_illegal(S_AXI.awsize, S_AXI.awburst, S_AXI.awlen);
            w_beat        <= '0;
            w_over        <= 1'b0;
            w_dec         <= 1'b0;
            w_state       <= W_DATA;
          end else begin
            S_AXI.awready <= 1'b1;
          end
        end
        // wlast closes the burst even when it disagrees with awlen.
        W_DATA: begin
          if (S_AXI.wvalid && S_AXI.wready) begin
            w_addr <= w_next;
            w_beat <= w_beat + 8'd1;
            if (!w_in_range)
              w_dec <= 1'b1;
            if (S_AXI.wlast) begin
              S_AXI.wready <= 1'b0;
              S_AXI.bvalid <= 1'b1;
              if (w_err || w_over || (w_beat != w_len))
                S_AXI.bresp <= RESP_SLVERR;
              else if (w_dec || !w_in_range)
                S_AXI.bresp <= RESP_DECERR;
              else
                S_AXI.bresp <= RESP_OKAY;
              w_state <= W_RESP;
            end else if (w_beat == w_len) begin
              w_over <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI.bready) begin
            S_AXI.bvalid  <= 1'b0;
            S_AXI.awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // The next beat is fetched at the same edge the current one is accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_err         <= 1'b0;
      S_AXI.arready <= 1'b0;
      S_AXI.rvalid  <= 1'b0;
      S_AXI.rlast   <= 1'b0;
      S_AXI.rresp   <= RESP_OKAY;
      S_AXI.rid     <= '0;
      S_AXI.rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI.arvalid && S_AXI.arready) begin
            S_AXI.arready <= 1'b0;
            S_AXI.rid     <= S_AXI.arid;
            r_addr        <= S_AXI.araddr;
            r_len         <= S_AXI.arlen;
            r_size        <= S_AXI.arsize;
            r_burst       <= S_AXI.arburst;
            r_err         <= burst_illegal(S_AXI.arsize, S_AXI.arburst, S_AXI.arlen);
            r_state       <= R_FETCH;
          end else begin
            S_AXI.arready <= 1'b1;
          end
        end
        R_FETCH: begin
          S_AXI.rvalid <= 1'b1;
          S_AXI.rdata  <= r_beat_data;
          S_AXI.rresp  <= r_beat_resp;
          S_AXI.rlast  <= (r_len == 8'd0);
          r_beat       <= '0;
          r_state      <= R_DATA;
        end
        R_DATA: begin
          if (S_AXI.rready) begin
            if (S_AXI.rlast) begin
              S_AXI.rvalid  <= 1'b0;
              S_AXI.rlast   <= 1'b0;
              S_AXI.arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_next;
              r_beat      <= r_beat + 8'd1;
              S_AXI.rdata <= r_beat_data;
              S_AXI.rresp <= r_beat_resp;
              S_AXI.rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_memory_slave.sv
// Directed self-checking bench for axi_burst_memory_slave (32-bit bus, 1024 words).
module tb_axi_burst_memory_slave;
  logic ACLK;
  logic ARESETN;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] wd [16];
  logic [31:0] exp_rd [16];
  bit          rr_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0]  resp;
  logic [3:0]  id_out;

  axi_burst_memory_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  axi_burst_memory_slave dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .S_AXI   (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed=no handshake expected=handshake within 20 cycles", tag);
  endtask

  task automatic setWrite(input logic [31:0] a, b, c, d);
    wd[0] = a; wd[1] = b; wd[2] = c; wd[3] = d;
  endtask

  task automatic setExpect(input logic [31:0] a, b, c, d);
    exp_rd[0] = a; exp_rd[1] = b; exp_rd[2] = c; exp_rd[3] = d;
  endtask

  task automatic applyWrite(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input logic [3:0] strb,
                            input int nbeats, output logic [1:0] rsp, output logic [3:0] bid);
    int n;
    rsp = 'x;
    bid = 'x;
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awid = id; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeoutFail("aw handshake");
    @(negedge ACLK);
    bus.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wdata = wd[i]; bus.wstrb = strb; bus.wlast = (i == nbeats - 1); bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 20) begin @(negedge ACLK); n++; end
      if (n >= 20) timeoutFail("w handshake");
      @(negedge ACLK);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeoutFail("b handshake");
    rsp = bus.bresp;
    bid = bus.bid;
    @(negedge ACLK);
    bus.bready = 1'b0;
  endtask

  task automatic applyRead(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [1:0] exp_resp,
                           input bit stall, input string tag);
    int  n, lat, got, c;
    bit  done;
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arid = id; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeoutFail({tag, " ar handshake"});
    lat = 0;
    do begin
      @(negedge ACLK);
      bus.arvalid = 1'b0;
      lat++;
    end while (!bus.rvalid && lat < 10);
    checkOutput({tag, " first rvalid latency"}, lat, 2);
    checkOutput({tag, " rid"}, bus.rid, id);
    got = 0; c = 0; done = 0;
    while (!done && c < 64 && got < 16) begin
      if (bus.rvalid) begin
        bus.rready = stall ? rr_pat[c % 4] : 1'b1;
        checkOutput($sformatf("%s beat%0d rdata", tag, got), bus.rdata, exp_rd[got]);
        if (bus.rready) begin
          checkOutput($sformatf("%s beat%0d rresp", tag, got), bus.rresp, exp_resp);
          checkOutput($sformatf("%s beat%0d rlast", tag, got), bus.rlast, (got == int'(len)));
          got++;
          if (bus.rlast) done = 1;
        end
      end
      @(negedge ACLK);
      c++;
    end
    bus.rready = 1'b0;
    checkOutput({tag, " beat count"}, got, int'(len) + 1);
    if (!stall) checkOutput({tag, " burst cycles"}, c, int'(len) + 1);
  endtask

  initial begin
    ARESETN = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset values, then readies one cycle after release.
    repeat (3) @(negedge ACLK);
    checkOutput("reset handshakes", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 6'b0);
    checkOutput("reset resp", {bus.bresp, bus.rresp}, 4'b0);
    checkOutput("reset ids", {bus.bid, bus.rid}, 8'b0);
    checkOutput("reset rdata", bus.rdata, 32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checkOutput("awready after release", bus.awready, 1'b1);
    checkOutput("arready after release", bus.arready, 1'b1);

    // INCR burst write and readback.
    setWrite(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    applyWrite(32'h10, 8'd3, 3'd2, 2'b01, 4'd5, 4'hF, 4, resp, id_out);
    checkOutput("incr bresp", resp, 2'b00);
    checkOutput("incr bid", id_out, 4'd5);
    setExpect(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    applyRead(32'h10, 8'd3, 3'd2, 2'b01, 4'd9, 2'b00, 1'b0, "incr read");

    // WRAP burst lands at 0x38,0x3C,0x30,0x34.
    setWrite(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    applyWrite(32'h38, 8'd3, 3'd2, 2'b10, 4'd2, 4'hF, 4, resp, id_out);
    checkOutput("wrap bresp", resp, 2'b00);
    setExpect(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    applyRead(32'h38, 8'd3, 3'd2, 2'b10, 4'd3, 2'b00, 1'b0, "wrap read");
    setExpect(32'hB2, 32'hB3, 32'hB0, 32'hB1);
    applyRead(32'h30, 8'd3, 3'd2, 2'b01, 4'd4, 2'b00, 1'b0, "wrap layout");

    // Byte strobes.
    setWrite(32'hFFFF_FFFF, 0, 0, 0);
    applyWrite(32'h80, 8'd0, 3'd2, 2'b01, 4'd1, 4'hF, 1, resp, id_out);
    setWrite(32'h1122_3344, 0, 0, 0);
    applyWrite(32'h80, 8'd0, 3'd2, 2'b01, 4'd1, 4'h5, 1, resp, id_out);
    checkOutput("strobe bresp", resp, 2'b00);
    setExpect(32'hFF22_FF44, 0, 0, 0);
    applyRead(32'h80, 8'd0, 3'd2, 2'b01, 4'd6, 2'b00, 1'b0, "strobe read");

    // rready pattern 1,0,0,1 stalls the read.
    setExpect(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    applyRead(32'h10, 8'd3, 3'd2, 2'b01, 4'd7, 2'b00, 1'b1, "stall read");

    // FIXED burst rewrites one word.
    setWrite(32'hC0, 32'hC1, 32'hC2, 0);
    applyWrite(32'h40, 8'd2, 3'd2, 2'b00, 4'd8, 4'hF, 3, resp, id_out);
    checkOutput("fixed bresp", resp, 2'b00);
    setExpect(32'hC2, 32'hC2, 0, 0);
    applyRead(32'h40, 8'd1, 3'd2, 2'b00, 4'd8, 2'b00, 1'b0, "fixed read");

    // Illegal bursts: SLVERR, zero data, memory untouched.
    setExpect(0, 0, 0, 0);
    applyRead(32'h10, 8'd2, 3'd2, 2'b11, 4'd10, 2'b10, 1'b0, "reserved burst read");
    setWrite(32'hDEAD_BEEF, 0, 0, 0);
    applyWrite(32'h10, 8'd0, 3'd2, 2'b11, 4'd11, 4'hF, 1, resp, id_out);
    checkOutput("reserved burst bresp", resp, 2'b10);
    applyWrite(32'h14, 8'd0, 3'd3, 2'b01, 4'd12, 4'hF, 1, resp, id_out);
    checkOutput("oversize bresp", resp, 2'b10);
    setWrite(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    applyWrite(32'h18, 8'd2, 3'd2, 2'b10, 4'd13, 4'hF, 3, resp, id_out);
    checkOutput("wrap len2 bresp", resp, 2'b10);
    setExpect(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    applyRead(32'h10, 8'd3, 3'd2, 2'b01, 4'd1, 2'b00, 1'b0, "after illegal");

    // wlast early and late.
    setWrite(32'h1, 32'h2, 32'h3, 32'h4);
    applyWrite(32'h200, 8'd3, 3'd2, 2'b01, 4'd3, 4'hF, 2, resp, id_out);
    checkOutput("early wlast bresp", resp, 2'b10);
    applyWrite(32'h300, 8'd1, 3'd2, 2'b01, 4'd4, 4'hF, 3, resp, id_out);
    checkOutput("late wlast bresp", resp, 2'b10);
    setWrite(32'hE0, 0, 0, 0);
    applyWrite(32'h400, 8'd0, 3'd2, 2'b01, 4'd14, 4'hF, 1, resp, id_out);
    checkOutput("recovery bresp", resp, 2'b00);
    checkOutput("recovery bid", id_out, 4'd14);

    // Address beyond the 4 KiB window.
    setWrite(32'h5A5A_5A5A, 0, 0, 0);
    applyWrite(32'h1000, 8'd0, 3'd2, 2'b01, 4'd15, 4'hF, 1, resp, id_out);
`ifdef AXI_MEM_RANGE_CHECK_EN
    checkOutput("out of range bresp", resp, 2'b11);
    setExpect(0, 0, 0, 0);
    applyRead(32'h1000, 8'd0, 3'd2, 2'b01, 4'd15, 2'b11, 1'b0, "out of range read");
`else
    checkOutput("alias bresp", resp, 2'b00);
    setExpect(32'h5A5A_5A5A, 0, 0, 0);
    applyRead(32'h0, 8'd0, 3'd2, 2'b01, 4'd15, 2'b00, 1'b0, "alias read");
`endif

    // Reset during beat 2 of a 4-beat write.
    setWrite(32'h77, 0, 0, 0);
    applyWrite(32'h108, 8'd0, 3'd2, 2'b01, 4'd2, 4'hF, 1, resp, id_out);
    setWrite(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    bus.awaddr = 32'h100; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.awid = 4'd6; bus.awvalid = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.awready && n < 20) begin @(negedge ACLK); n++; end
      if (n >= 20) timeoutFail("abort aw handshake");
      @(negedge ACLK);
      bus.awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        bus.wdata = wd[i]; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        n = 0;
        while (!bus.wready && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) timeoutFail("abort w handshake");
        @(negedge ACLK);
      end
    end
    bus.wdata = wd[2]; bus.wvalid = 1'b1;
    ARESETN = 1'b0;
    #1;
    checkOutput("abort handshakes", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 5'b0);
    checkOutput("abort rdata", bus.rdata, 32'h0);
    @(negedge ACLK);
    bus.wvalid = 1'b0;
    ARESETN = 1'b1;
    @(negedge ACLK);
    checkOutput("abort awready after release", bus.awready, 1'b1);
    setExpect(32'hD0, 32'hD1, 0, 0);
    applyRead(32'h100, 8'd1, 3'd2, 2'b01, 4'd5, 2'b00, 1'b0, "abort kept beats");
    setExpect(32'h77, 0, 0, 0);
    applyRead(32'h108, 8'd0, 3'd2, 2'b01, 4'd5, 2'b00, 1'b0, "abort beat2 dropped");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
